pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameters SHALL be: NBITS=32, datapath/address width; NSTAGES=5, pipeline stage count, minimum 3; IMEM_DEPTH=256, instruction-memory words; HALT_OPCODE=32'hFFFF_FFFF, halt instruction encoding.
REQ-002 Ports SHALL be exactly (name  dir  width  meaning):
  i_clk  in  1  single clock, all logic rising-edge;
  i_rst  in  1  synchronous active-high reset;
  i_cmd_valid  in  1  command strobe;
  i_cmd  in  3  command: 0 NOP, 1 LOAD, 2 RUN, 3 STEP, 4 HALT, 5-7 ignored;
  o_cmd_ready  out  1  command accepted this cycle when high with i_cmd_valid;
  i_load_valid  in  1  load word strobe;
  i_load_data  in  NBITS  load word;
  i_load_last  in  1  final load word;
  i_hazard_detected  in  1  load-use hazard, freeze stages 0-1;
  i_stall_ex  in  1  inject bubble into stage 2;
  i_branch_taken  in  1  redirect, flush stages 0-1;
  i_instr_id  in  NBITS  instruction currently in stage 1 (decode);
  o_stage_en  out  NSTAGES  per-stage register enable, bit 0 = fetch;
  o_stage_flush  out  NSTAGES  per-stage register clear-to-bubble;
  o_imem_wr_en  out  1  instruction-memory write;
  o_imem_addr  out  NBITS  byte address;
  o_imem_data  out  NBITS  write data;
  o_cycle_cnt  out  NBITS  executed-cycle count;
  o_state  out  3  current state code;
  o_halted  out  1  high in HALTED.

Function
REQ-003 States SHALL be IDLE(0), LOAD(1), RUN(2), STEP(3), DRAIN(4), HALTED(5).
REQ-004 o_cmd_ready SHALL be high in IDLE, RUN, HALTED; low otherwise.
REQ-005 IDLE: LOAD->LOAD, RUN->RUN, STEP->STEP, HALT/NOP/unknown ignored.
REQ-006 RUN: only HALT accepted (->DRAIN); other commands consumed and ignored.
REQ-007 HALTED: only LOAD accepted (->LOAD); all others ignored.
REQ-008 LOAD entry SHALL zero the address pointer and o_cycle_cnt; each i_load_valid SHALL assert o_imem_wr_en for that same cycle with o_imem_addr=pointer, o_imem_data=i_load_data, then pointer += 4.
REQ-009 LOAD SHALL exit to IDLE the cycle after accepting a word with i_load_last, or after writing word IMEM_DEPTH-1; further words SHALL be dropped, pointer never wraps.
REQ-010 In IDLE, LOAD, HALTED, o_stage_en and o_stage_flush SHALL be all zero.
REQ-011 In RUN, o_stage_en SHALL be all ones except bits 0-1 cleared while i_hazard_detected, and flush bit 2 set while i_stall_ex or i_hazard_detected.
REQ-012 i_branch_taken SHALL set flush bits 0-1 and force en bits 0-1 high, overriding i_hazard_detected the same cycle.
REQ-013 In RUN, i_instr_id==HALT_OPCODE SHALL clear en bit 0, set flush bit 1, and enter DRAIN next cycle; branch flush in that cycle takes priority (no halt).
REQ-014 DRAIN SHALL last exactly NSTAGES-2 cycles with en bit 0 low, flush bit 1 high, other bits as RUN, then enter HALTED.
REQ-015 STEP SHALL last one cycle with RUN enables, then return to IDLE; a halt detected during STEP SHALL enter DRAIN instead.
REQ-016 o_cycle_cnt SHALL increment in RUN, STEP, DRAIN each cycle, saturating at all ones.
REQ-017 Simultaneous i_cmd_valid and i_load_valid in IDLE SHALL only accept the command; the load word is dropped.

Reset
REQ-018 While i_rst is high at a clock edge: state IDLE, all outputs zero, pointer and counters zero; reset SHALL take effect mid-LOAD, mid-DRAIN, mid-STEP identically.
REQ-019 First cycle after reset release SHALL accept a command.

Structure
REQ-020 Package pipeline_seq_pkg SHALL hold command encodings, state encoding and HALT_OPCODE default.
REQ-021 Saturating counter SHALL be sub-module seq_sat_counter (param WIDTH); all else in one FSM module.

Verification
REQ-022 LOAD of 3 words 0x11,0x22,0x33 (last on third) -> writes at 0x0,0x4,0x8; IDLE next cycle.
REQ-023 LOAD of 300 words, IMEM_DEPTH=256 -> last write at 0x3FC; 44 words dropped; IDLE.
REQ-024 RUN, i_hazard_detected for 2 cycles -> o_stage_en=5'b11100, o_stage_flush=5'b00100 both cycles.
REQ-025 RUN, hazard and branch same cycle -> o_stage_en=5'b11111, o_stage_flush=5'b00011.
REQ-026 RUN, i_instr_id=HALT_OPCODE at cycle 10 -> DRAIN 3 cycles, HALTED, o_cycle_cnt=14.
REQ-027 STEP twice from IDLE -> o_cycle_cnt=2; i_rst during DRAIN -> IDLE, outputs zero next cycle.

Source files
------------

// File: rtl/pipeline_seq_pkg.sv
// Shared encodings for the pipeline sequencer.
// Command codes, FSM state codes and default halt opcode.
package pipeline_seq_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_LOAD = 3'd1,
    CMD_RUN  = 3'd2,
    CMD_STEP = 3'd3,
    CMD_HALT = 3'd4
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  localparam logic [31:0] HALT_OPCODE_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Ports: i_clk, i_rst, i_clr, i_inc, o_count[WIDTH].
module seq_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt_q <= '0;
    end else if (i_inc && !(&cnt_q)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign o_count = cnt_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline control FSM: imem loader, run/step/drain/halt.
// Ports: cmd + load inputs, hazard/stall/branch, stage en/flush, imem write, status.
module pipeline_sequencer
  import pipeline_seq_pkg::*;
#(
  parameter int NBITS       = 32,
  parameter int NSTAGES     = 5,
  parameter int IMEM_DEPTH  = 256,
  parameter logic [NBITS-1:0] HALT_OPCODE = NBITS'(HALT_OPCODE_DEF)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  input  logic [2:0]         i_cmd,
  output logic               o_cmd_ready,
  input  logic               i_load_valid,
  input  logic [NBITS-1:0]   i_load_data,
  input  logic               i_load_last,
  input  logic               i_hazard_detected,
  input  logic               i_stall_ex,
  input  logic               i_branch_taken,
  input  logic [NBITS-1:0]   i_instr_id,
  output logic [NSTAGES-1:0] o_stage_en,
  output logic [NSTAGES-1:0] o_stage_flush,
  output logic               o_imem_wr_en,
  output logic [NBITS-1:0]   o_imem_addr,
  output logic [NBITS-1:0]   o_imem_data,
  output logic [NBITS-1:0]   o_cycle_cnt,
  output logic [2:0]         o_state,
  output logic               o_halted
);

  localparam int DW = $clog2(NSTAGES);
  localparam logic [NBITS-1:0] LAST_ADDR =
    NBITS'((IMEM_DEPTH - 1) * 4);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(NSTAGES - 3);

  state_e               state_q, state_d;
  logic [NBITS-1:0]     ptr_q, ptr_d;
  logic [DW-1:0]        drain_q, drain_d;

  logic [NSTAGES-1:0]   en, flush;
  logic [NSTAGES-1:0]   run_en, run_flush;
  logic                 ready, wr, clr, inc;
  logic                 haz, halt_hit;
  cmd_e                 cmd;

  assign cmd = cmd_e'(i_cmd);
  // A taken branch overrides the hazard freeze entirely.
  assign haz = i_hazard_detected & ~i_branch_taken;
  // Branch flush wins over halt detection.
  assign halt_hit = (i_instr_id == HALT_OPCODE) & ~i_branch_taken;

  always_comb begin
    run_en    = '1;
    run_flush = '0;
    if (haz) run_en[1:0] = 2'b00;
    run_flush[2] = i_stall_ex | haz;
    if (i_branch_taken) begin
      run_en[1:0]    = 2'b11;
      run_flush[1:0] = 2'b11;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    drain_d = drain_q;
    en      = '0;
    flush   = '0;
    ready   = 1'b0;
    wr      = 1'b0;
    clr     = 1'b0;
    inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (i_cmd_valid) begin
          case (cmd)
            CMD_LOAD: begin
              state_d = ST_LOAD;
              ptr_d   = '0;
              clr     = 1'b1;
            end
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            default:  ;
          endcase
        end
      end
      ST_LOAD: begin
        if (i_load_valid) begin
          wr    = 1'b1;
          ptr_d = ptr_q + NBITS'(4);
          if (i_load_last || ptr_q == LAST_ADDR)
            state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_STEP: begin
        ready = (state_q == ST_RUN);
        inc   = 1'b1;
        en    = run_en;
        flush = run_flush;
        if (state_q == ST_STEP) state_d = ST_IDLE;
        if (halt_hit) begin
          en[0]    = 1'b0;
          flush[1] = 1'b1;
        end
        if (halt_hit || (ready && i_cmd_valid &&
                         cmd == CMD_HALT)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        inc      = 1'b1;
        en       = run_en;
        flush    = run_flush;
        en[0]    = 1'b0;
        flush[1] = 1'b1;
        if (drain_q == DRAIN_LAST) state_d = ST_HALTED;
        else drain_d = drain_q + DW'(1);
      end
      ST_HALTED: begin
        ready = 1'b1;
        if (i_cmd_valid && cmd == CMD_LOAD) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          clr     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      drain_q <= drain_d;
    end
  end

  seq_sat_counter #(.WIDTH(NBITS)) u_cyc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (clr),
    .i_inc  (inc),
    .o_count(o_cycle_cnt)
  );

  // Strobes are masked while reset is held.
  assign o_cmd_ready   = ready & ~i_rst;
  assign o_stage_en    = i_rst ? '0 : en;
  assign o_stage_flush = i_rst ? '0 : flush;
  assign o_imem_wr_en  = wr & ~i_rst;
  assign o_imem_data   = o_imem_wr_en ? i_load_data : '0;
  assign o_imem_addr   = ptr_q;
  assign o_state       = state_q;
  assign o_halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer.
// Drives on falling edge, checks 1ns later.
module tb_pipeline_sequencer;
  import pipeline_seq_pkg::*;

  localparam int NB = 32;
  localparam int NS = 5;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready;
  logic [2:0] cmd;
  logic load_valid, load_last;
  logic [NB-1:0] load_data;
  logic hazard, stall, branch;
  logic [NB-1:0] instr;
  logic [NS-1:0] stage_en, stage_flush;
  logic wr_en;
  logic [NB-1:0] addr, wdata, cyc;
  logic [2:0] state;
  logic halted;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipeline_sequencer dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cmd_valid      (cmd_valid),
    .i_cmd            (cmd),
    .o_cmd_ready      (cmd_ready),
    .i_load_valid     (load_valid),
    .i_load_data      (load_data),
    .i_load_last      (load_last),
    .i_hazard_detected(hazard),
    .i_stall_ex       (stall),
    .i_branch_taken   (branch),
    .i_instr_id       (instr),
    .o_stage_en       (stage_en),
    .o_stage_flush    (stage_flush),
    .o_imem_wr_en     (wr_en),
    .o_imem_addr      (addr),
    .o_imem_data      (wdata),
    .o_cycle_cnt      (cyc),
    .o_state          (state),
    .o_halted         (halted)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] c);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd = 3'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd = 3'd1;
    @(negedge clk);
    #1;
    total++;
    if ({stage_en, stage_flush, wr_en, cmd_ready, halted} !== '0 ||
        state !== 3'd0 || cyc !== '0 || addr !== '0)
      $display("FAIL reset_outputs: en=%b fl=%b wr=%b rdy=%b st=%0d cyc=%0d",
               stage_en, stage_flush, wr_en, cmd_ready, state, cyc);
    else passed++;
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1)
      $display("FAIL ready_after_reset: got %b want 1", cmd_ready);
    else passed++;
    cmd_valid = 1'b1;
    cmd = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    total++;
    if (state !== 3'd2)
      $display("FAIL first_cmd_accept: state=%0d want 2", state);
    else passed++;
    do_reset();
  endtask

  task automatic test_load3();
    logic [NB-1:0] words [3];
    words[0] = 32'h11;
    words[1] = 32'h22;
    words[2] = 32'h33;
    send_cmd(3'd1);
    #1;
    total++;
    if (state !== 3'd1 || cmd_ready !== 1'b0)
      $display("FAIL load_enter: state=%0d rdy=%b want 1/0", state, cmd_ready);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data = words[i];
      load_last = (i == 2);
      #1;
      total++;
      if (wr_en !== 1'b1 || addr !== NB'(i * 4) || wdata !== words[i])
        $display("FAIL load3_w%0d: wr=%b addr=%h data=%h want 1/%h/%h",
                 i, wr_en, addr, wdata, i * 4, words[i]);
      else passed++;
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    #1;
    total++;
    if (state !== 3'd0 || wr_en !== 1'b0)
      $display("FAIL load3_exit: state=%0d wr=%b want 0/0", state, wr_en);
    else passed++;
  endtask

  task automatic test_load_overflow();
    int writes;
    logic [NB-1:0] last_addr;
    writes = 0;
    last_addr = '0;
    send_cmd(3'd1);
    for (int i = 0; i < 300; i++) begin
      load_valid = 1'b1;
      load_data = NB'(i);
      #1;
      if (wr_en === 1'b1) begin
        writes++;
        last_addr = addr;
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    #1;
    total++;
    if (writes != 256 || 300 - writes != 44)
      $display("FAIL ovf_count: writes=%0d want 256", writes);
    else passed++;
    total++;
    if (last_addr !== 32'h3FC)
      $display("FAIL ovf_last_addr: got %h want 3fc", last_addr);
    else passed++;
    total++;
    if (state !== 3'd0)
      $display("FAIL ovf_state: got %0d want 0", state);
    else passed++;
  endtask

  task automatic test_cmd_vs_load();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = 3'd1;
    load_valid = 1'b1;
    load_data = 32'hDEAD;
    #1;
    total++;
    if (wr_en !== 1'b0)
      $display("FAIL cmd_load_drop: wr=%b want 0", wr_en);
    else passed++;
    @(negedge clk);
    cmd_valid = 1'b0;
    load_data = 32'h55;
    load_last = 1'b1;
    #1;
    total++;
    if (state !== 3'd1 || wr_en !== 1'b1 || addr !== '0 || wdata !== 32'h55)
      $display("FAIL cmd_load_next: st=%0d wr=%b addr=%h d=%h want 1/1/0/55",
               state, wr_en, addr, wdata);
    else passed++;
    @(negedge clk);
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask

  task automatic test_run_controls();
    do_reset();
    send_cmd(3'd2);
    hazard = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (stage_en !== 5'b11100 || stage_flush !== 5'b00100)
        $display("FAIL hazard_c%0d: en=%b fl=%b want 11100/00100",
                 i, stage_en, stage_flush);
      else passed++;
      @(negedge clk);
    end
    branch = 1'b1;
    #1;
    total++;
    if (stage_en !== 5'b11111 || stage_flush !== 5'b00011)
      $display("FAIL hazard_branch: en=%b fl=%b want 11111/00011",
               stage_en, stage_flush);
    else passed++;
    @(negedge clk);
    hazard = 1'b0;
    branch = 1'b0;
    stall = 1'b1;
    #1;
    total++;
    if (stage_en !== 5'b11111 || stage_flush !== 5'b00100)
      $display("FAIL stall_ex: en=%b fl=%b want 11111/00100",
               stage_en, stage_flush);
    else passed++;
    @(negedge clk);
    stall = 1'b0;
    instr = HALT;
    branch = 1'b1;
    #1;
    total++;
    if (stage_en !== 5'b11111 || stage_flush !== 5'b00011)
      $display("FAIL halt_vs_branch_out: en=%b fl=%b want 11111/00011",
               stage_en, stage_flush);
    else passed++;
    @(negedge clk);
    instr = '0;
    branch = 1'b0;
    #1;
    total++;
    if (state !== 3'd2 || stage_en !== 5'b11111 || stage_flush !== 5'b0)
      $display("FAIL halt_vs_branch_st: st=%0d en=%b fl=%b want 2/11111/0",
               state, stage_en, stage_flush);
    else passed++;
    send_cmd(3'd3);
    #1;
    total++;
    if (state !== 3'd2)
      $display("FAIL run_ignore_step: st=%0d want 2", state);
    else passed++;
    send_cmd(3'd4);
    #1;
    total++;
    if (state !== 3'd4)
      $display("FAIL run_halt_cmd: st=%0d want 4", state);
    else passed++;
  endtask

  task automatic test_halt_drain();
    do_reset();
    send_cmd(3'd2);
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (cyc !== 32'd10)
      $display("FAIL run_cnt10: got %0d want 10", cyc);
    else passed++;
    instr = HALT;
    #1;
    total++;
    if (stage_en !== 5'b11110 || stage_flush !== 5'b00010)
      $display("FAIL halt_detect: en=%b fl=%b want 11110/00010",
               stage_en, stage_flush);
    else passed++;
    @(negedge clk);
    instr = '0;
    for (int d = 0; d < 3; d++) begin
      #1;
      total++;
      if (state !== 3'd4 || stage_en !== 5'b11110 ||
          stage_flush !== 5'b00010 || cmd_ready !== 1'b0)
        $display("FAIL drain_c%0d: st=%0d en=%b fl=%b rdy=%b want 4/11110/00010/0",
                 d, state, stage_en, stage_flush, cmd_ready);
      else passed++;
      @(negedge clk);
    end
    #1;
    total++;
    if (state !== 3'd5 || halted !== 1'b1 || cyc !== 32'd14 ||
        stage_en !== '0 || stage_flush !== '0)
      $display("FAIL halted: st=%0d h=%b cyc=%0d en=%b want 5/1/14/0",
               state, halted, cyc, stage_en);
    else passed++;
    send_cmd(3'd2);
    #1;
    total++;
    if (state !== 3'd5 || cyc !== 32'd14)
      $display("FAIL halted_ignore_run: st=%0d cyc=%0d want 5/14", state, cyc);
    else passed++;
    send_cmd(3'd1);
    #1;
    total++;
    if (state !== 3'd1 || cyc !== '0 || addr !== '0)
      $display("FAIL halted_load: st=%0d cyc=%0d addr=%h want 1/0/0",
               state, cyc, addr);
    else passed++;
  endtask

  task automatic test_step();
    do_reset();
    send_cmd(3'd3);
    #1;
    total++;
    if (state !== 3'd3 || stage_en !== 5'b11111 || cmd_ready !== 1'b0)
      $display("FAIL step_state: st=%0d en=%b rdy=%b want 3/11111/0",
               state, stage_en, cmd_ready);
    else passed++;
    @(negedge clk);
    send_cmd(3'd3);
    @(negedge clk);
    #1;
    total++;
    if (state !== 3'd0 || cyc !== 32'd2)
      $display("FAIL step_twice: st=%0d cyc=%0d want 0/2", state, cyc);
    else passed++;
    send_cmd(3'd3);
    instr = HALT;
    @(negedge clk);
    instr = '0;
    #1;
    total++;
    if (state !== 3'd4)
      $display("FAIL step_halt: st=%0d want 4", state);
    else passed++;
  endtask

  task automatic test_reset_drain();
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (state !== 3'd0 || stage_en !== '0 || stage_flush !== '0 ||
        cyc !== '0 || halted !== 1'b0)
      $display("FAIL reset_in_drain: st=%0d en=%b fl=%b cyc=%0d want 0/0/0/0",
               state, stage_en, stage_flush, cyc);
    else passed++;
    rst = 1'b0;
    send_cmd(3'd1);
    load_valid = 1'b1;
    load_data = 32'h1;
    @(negedge clk);
    rst = 1'b1;
    load_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (state !== 3'd0 || addr !== '0 || wr_en !== 1'b0)
      $display("FAIL reset_in_load: st=%0d addr=%h wr=%b want 0/0/0",
               state, addr, wr_en);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd = 3'd0;
    load_valid = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    hazard = 1'b0;
    stall = 1'b0;
    branch = 1'b0;
    instr = '0;
    test_reset();
    test_load3();
    test_load_overflow();
    test_cmd_vs_load();
    test_run_controls();
    test_halt_drain();
    test_step();
    test_reset_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
